router_input_buffer: RTL and testbench

- Per-port ingress FIFO that sits directly upstream of forward_north.
- Buffers 16-bit packets arriving from a link and presents one packet at a time on packet_out/valid_out, which connect to the forward stage's packet_in/valid_in.
- Adds ready-based backpressure: the link is stalled while the buffer is full, and the buffer holds its head packet while the forward stage is not ready.

---
 rtl/router_pkg.sv | 18 +
 rtl/router_buf_mem.sv | 27 ++
 rtl/router_input_buffer.sv | 89 ++++++++
 tb/tb_router_input_buffer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: packet width, header field positions and the packet type.
package router_pkg;

    localparam int PKT_W      = 16;
    localparam int DX_HI      = 15;
    localparam int DX_LO      = 12;
    localparam int DY_HI      = 11;
    localparam int DY_LO      = 8;
    localparam int PAYLOAD_HI = 7;
    localparam int PAYLOAD_LO = 0;

    typedef logic [PKT_W-1:0] packet_t;

    function automatic logic [DY_HI-DY_LO:0] pkt_dy(input packet_t pkt);
        return pkt[DY_HI:DY_LO];
    endfunction

endpackage

// File: rtl/router_buf_mem.sv
// DEPTH x PKT_W packet storage: one synchronous write port, one asynchronous read port.
module router_buf_mem
    import router_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PKT_W = router_pkg::PKT_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [PKT_W-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [PKT_W-1:0]         rdata
);

    // Storage is deliberately not reset; occupancy tracking alone decides validity.
    logic [PKT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_input_buffer.sv
// Per-port ingress FIFO feeding the forward stage, with ready-based backpressure.
// Optional zero-latency cut-through when empty: define ROUTER_BUF_BYPASS_EN.
module router_input_buffer
    import router_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PKT_W = router_pkg::PKT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PKT_W-1:0]         packet_in,
    input  logic                     valid_in,
    output logic                     ready_in,
    output logic [PKT_W-1:0]         packet_out,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [PKT_W-1:0] mem_rdata;
    logic             push;
    logic             pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    // Space is judged on the registered count, so a same-cycle pop never frees room for a push.
    assign ready_in = !full;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // Upstream: push = valid_in && ready_in. Downstream: pop = valid_out && ready_out;
    // while valid_out is high and ready_out low, packet_out and valid_out hold unchanged.
`ifdef ROUTER_BUF_BYPASS_EN
    logic bypass_take;

    // An empty buffer lets the arriving packet straight through; it is stored only if not taken.
    assign bypass_take = empty && valid_in && ready_out;
    assign valid_out   = !empty || valid_in;
    assign packet_out  = !empty ? mem_rdata : (valid_in ? packet_in : '0);
    assign push        = valid_in && ready_in && !bypass_take;
    assign pop         = !empty && ready_out;
`else
    assign valid_out   = !empty;
    assign packet_out  = empty ? '0 : mem_rdata;
    assign push        = valid_in && ready_in;
    assign pop         = valid_out && ready_out;
`endif

    router_buf_mem #(
        .DEPTH (DEPTH),
        .PKT_W (PKT_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (packet_in),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    // Pointers wrap naturally at their AW-bit width since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_router_input_buffer.sv
// Directed self-checking bench for router_input_buffer (DEPTH=4, PKT_W=16).
module tb_router_input_buffer;

    logic        clk;
    logic        rst;
    logic [15:0] packet_in;
    logic        valid_in;
    logic        ready_in;
    logic [15:0] packet_out;
    logic        valid_out;
    logic        ready_out;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int n_vec;
    int n_err;
    logic [15:0] exp_q[$];
    logic [15:0] exp_pkt;

    router_input_buffer #(
        .DEPTH (4),
        .PKT_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .packet_in  (packet_in),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .packet_out (packet_out),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input logic [15:0] pkt);
        packet_in = pkt;
        valid_in  = 1'b1;
        tick();
        valid_in  = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        valid_in  = 1'b1;
        packet_in = 16'hABCD;
        ready_out = 1'b0;
        tick();
        tick();
        valid_in = 1'b0;
        #1;
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
        n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_out got %b want 0", valid_out); end
        n_vec++; if (packet_out !== 16'h0000) begin n_err++; $display("FAIL reset_packet_out got %h want 0000", packet_out); end
        n_vec++; if (ready_in !== 1'b1) begin n_err++; $display("FAIL reset_ready_in got %b want 1", ready_in); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        ready_out = 1'b0;
        push_pkt(16'h0200);
        n_vec++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", valid_out); end
        n_vec++; if (packet_out !== 16'h0200) begin n_err++; $display("FAIL single_pkt got %h want 0200", packet_out); end
        n_vec++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count got %0d want 1", count); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (valid_out !== 1'b1 || packet_out !== 16'h0200)
                begin n_err++; $display("FAIL single_hold%0d got %b/%h want 1/0200", i, valid_out, packet_out); end
        end
        ready_out = 1'b1;
        tick();
        n_vec++; if (empty !== 1'b1 || valid_out !== 1'b0 || packet_out !== 16'h0000)
            begin n_err++; $display("FAIL single_pop got empty=%b valid=%b pkt=%h want 1/0/0000", empty, valid_out, packet_out); end
        // ready_out while empty must not move anything
        tick();
        n_vec++; if (count !== 3'd0 || ready_in !== 1'b1)
            begin n_err++; $display("FAIL empty_ready_out got count=%0d ready_in=%b want 0/1", count, ready_in); end
        ready_out = 1'b0;
    endtask

    task automatic test_fill_order();
        ready_out = 1'b0;
        exp_q.delete();
        for (int i = 1; i <= 4; i++) begin
            push_pkt(16'(i * 16'h0100));
            exp_q.push_back(16'(i * 16'h0100));
        end
        n_vec++; if (full !== 1'b1 || ready_in !== 1'b0 || count !== 3'd4)
            begin n_err++; $display("FAIL fill_full got full=%b ready_in=%b count=%0d want 1/0/4", full, ready_in, count); end
        push_pkt(16'h0500);
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_refuse got count %0d want 4", count); end
        ready_out = 1'b1;
        while (exp_q.size() > 0) begin
            exp_pkt = exp_q.pop_front();
            n_vec++; if (valid_out !== 1'b1 || packet_out !== exp_pkt)
                begin n_err++; $display("FAIL fill_drain got %b/%h want 1/%h", valid_out, packet_out, exp_pkt); end
            tick();
        end
        ready_out = 1'b0;
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL fill_empty got %b want 1", empty); end
    endtask

    task automatic test_back_to_back();
        ready_out = 1'b0;
        exp_q.delete();
        push_pkt(16'h1100);
        push_pkt(16'h1101);
        exp_q.push_back(16'h1100);
        exp_q.push_back(16'h1101);
        n_vec++; if (count !== 3'd2) begin n_err++; $display("FAIL b2b_start got count %0d want 2", count); end
        ready_out = 1'b1;
        valid_in  = 1'b1;
        for (int k = 2; k < 12; k++) begin
            packet_in = 16'h1100 + 16'(k);
            exp_pkt = exp_q.pop_front();
            n_vec++; if (packet_out !== exp_pkt)
                begin n_err++; $display("FAIL b2b_pkt%0d got %h want %h", k, packet_out, exp_pkt); end
            exp_q.push_back(packet_in);
            tick();
            n_vec++; if (count !== 3'd2) begin n_err++; $display("FAIL b2b_count%0d got %0d want 2", k, count); end
        end
        valid_in = 1'b0;
        while (exp_q.size() > 0) begin
            exp_pkt = exp_q.pop_front();
            n_vec++; if (valid_out !== 1'b1 || packet_out !== exp_pkt)
                begin n_err++; $display("FAIL b2b_drain got %b/%h want 1/%h", valid_out, packet_out, exp_pkt); end
            tick();
        end
        ready_out = 1'b0;
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty got %b want 1", empty); end
    endtask

    task automatic test_full_push_pop();
        ready_out = 1'b0;
        for (int i = 0; i < 4; i++) push_pkt(16'h2200 + 16'(i));
        packet_in = 16'h2204;
        valid_in  = 1'b1;
        ready_out = 1'b1;
        tick();
        n_vec++; if (count !== 3'd3 || ready_in !== 1'b1)
            begin n_err++; $display("FAIL fullpp_refuse got count=%0d ready_in=%b want 3/1", count, ready_in); end
        n_vec++; if (packet_out !== 16'h2201) begin n_err++; $display("FAIL fullpp_head got %h want 2201", packet_out); end
        ready_out = 1'b0;
        tick();
        valid_in = 1'b0;
        n_vec++; if (count !== 3'd4 || full !== 1'b1)
            begin n_err++; $display("FAIL fullpp_retry got count=%0d full=%b want 4/1", count, full); end
        ready_out = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_vec++; if (packet_out !== 16'h2200 + 16'(i))
                begin n_err++; $display("FAIL fullpp_drain%0d got %h want %h", i, packet_out, 16'h2200 + 16'(i)); end
            tick();
        end
        ready_out = 1'b0;
    endtask

    task automatic test_mid_reset();
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) push_pkt(16'h3300 + 16'(i));
        n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL midrst_pre got count %0d want 3", count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (count !== 3'd0 || valid_out !== 1'b0)
            begin n_err++; $display("FAIL midrst_clear got count=%0d valid=%b want 0/0", count, valid_out); end
`ifdef ROUTER_BUF_BYPASS_EN
        packet_in = 16'h0000;
        valid_in  = 1'b1;
        ready_out = 1'b1;
        #1;
        n_vec++; if (valid_out !== 1'b1 || packet_out !== 16'h0000)
            begin n_err++; $display("FAIL bypass_out got %b/%h want 1/0000", valid_out, packet_out); end
        tick();
        valid_in  = 1'b0;
        ready_out = 1'b0;
        #1;
        n_vec++; if (count !== 3'd0 || empty !== 1'b1)
            begin n_err++; $display("FAIL bypass_count got count=%0d empty=%b want 0/1", count, empty); end
`else
        push_pkt(16'h0000);
        n_vec++; if (valid_out !== 1'b1 || packet_out !== 16'h0000 || count !== 3'd1)
            begin n_err++; $display("FAIL midrst_push got %b/%h/%0d want 1/0000/1", valid_out, packet_out, count); end
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL midrst_pop got empty %b want 1", empty); end
`endif
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        valid_in  = 1'b0;
        ready_out = 1'b0;
        packet_in = '0;
        test_reset();
        test_single();
        test_fill_order();
        test_back_to_back();
        test_full_push_pop();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
